// File: rtl/palette_color_mapper.sv
// Programmable palette colour mapper: pixel index -> R/G/B through a double-buffered
// palette (shadow written by host, copied to active at a committing frame_start).
module palette_color_mapper #(
   parameter int unsigned COLOR_BITS = 3,
   parameter int unsigned CH_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    pix_valid,
   input  logic [COLOR_BITS-1:0]   pix_color,
   input  logic                    pix_blank,
   input  logic                    frame_start,
   input  logic                    pal_we,
   input  logic [COLOR_BITS-1:0]   pal_addr,
   input  logic [3*CH_WIDTH-1:0]   pal_data,
   input  logic                    pal_commit,
   output logic                    commit_pending,
   output logic                    out_valid,
   output logic [CH_WIDTH-1:0]     R,
   output logic [CH_WIDTH-1:0]     G,
   output logic [CH_WIDTH-1:0]     B
);

   localparam int unsigned DEPTH = 1 << COLOR_BITS;
   localparam int unsigned PW    = 3 * CH_WIDTH;

   logic [PW-1:0]         shadow [DEPTH];
   logic [PW-1:0]         active [DEPTH];
   logic                  s1_valid;
   logic                  s1_blank;
   logic [COLOR_BITS-1:0] s1_color;
   logic                  do_commit;
   logic [PW-1:0]         lookup;

   // Reset palette contents, scaled so the 8-bit reference colours keep their MSB alignment.
   function automatic logic [PW-1:0] def_entry(input int unsigned idx);
      logic [CH_WIDTH-1:0] r, g, b;
      r = '0;
      g = '0;
      b = '0;
      if (idx == 0) begin
         r = CH_WIDTH'(8'h11) << (CH_WIDTH - 8);
         g = CH_WIDTH'(8'h20) << (CH_WIDTH - 8);
         b = CH_WIDTH'(8'h33) << (CH_WIDTH - 8);
      end else if (idx == 1) begin
         r = CH_WIDTH'(8'hfd) << (CH_WIDTH - 8);
         g = CH_WIDTH'(8'h61) << (CH_WIDTH - 8);
         b = CH_WIDTH'(8'h0c) << (CH_WIDTH - 8);
      end
      return {r, g, b};
   endfunction

   // A same-cycle pal_commit counts as pending so frame_start can apply it at once.
   always_comb begin
      do_commit = frame_start & (commit_pending | pal_commit);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_pending <= 1'b0;
      end else if (do_commit) begin
         commit_pending <= 1'b0;
      end else if (pal_commit) begin
         commit_pending <= 1'b1;
      end
   end

   // Active copies the pre-write shadow, so a coincident pal_we reaches shadow only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            shadow[i] <= def_entry(i);
            active[i] <= def_entry(i);
         end
      end else begin
         if (do_commit) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               active[i] <= shadow[i];
            end
         end
         if (pal_we) begin
            shadow[pal_addr] <= pal_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_blank <= 1'b0;
         s1_color <= '0;
      end else begin
         s1_valid <= pix_valid;
         s1_blank <= pix_blank;
         s1_color <= pix_color;
      end
   end

   always_comb begin
      lookup = '0;
      if (s1_valid && !s1_blank) begin
         lookup = active[s1_color];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         R         <= '0;
         G         <= '0;
         B         <= '0;
      end else begin
         out_valid <= s1_valid;
         R         <= lookup[3*CH_WIDTH-1:2*CH_WIDTH];
         G         <= lookup[2*CH_WIDTH-1:CH_WIDTH];
         B         <= lookup[CH_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_palette_color_mapper.sv
// Randomised and directed bench for palette_color_mapper against a behavioural
// palette/queue model.
module tb_palette_color_mapper;

   localparam int unsigned CB = 3;
   localparam int unsigned CW = 8;
   localparam int unsigned D  = 1 << CB;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          pix_valid, pix_blank, frame_start, pal_we, pal_commit;
   logic [CB-1:0] pix_color, pal_addr;
   logic [3*CW-1:0] pal_data;
   logic          commit_pending, out_valid;
   logic [CW-1:0] R, G, B;

   int errors = 0;
   int checks = 0;

   // Model state: palettes as whole RGB words, pending flag, and expected outputs in flight.
   logic [23:0] m_sh  [D];
   logic [23:0] m_act [D];
   logic        m_pend;
   logic [24:0] inflight [$];
   logic [24:0] m_out;

   palette_color_mapper #(.COLOR_BITS(CB), .CH_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .pix_valid(pix_valid), .pix_color(pix_color), .pix_blank(pix_blank),
      .frame_start(frame_start), .pal_we(pal_we), .pal_addr(pal_addr),
      .pal_data(pal_data), .pal_commit(pal_commit),
      .commit_pending(commit_pending), .out_valid(out_valid),
      .R(R), .G(G), .B(B)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(D); i++) begin
         m_sh[i]  = (i == 0) ? 24'h112033 : (i == 1) ? 24'hfd610c : 24'h0;
         m_act[i] = m_sh[i];
      end
      m_pend = 1'b0;
      inflight = {25'h0, 25'h0};
      m_out = 25'h0;
   endtask

   task automatic pix(input logic v, input logic [CB-1:0] c, input logic b);
      pix_valid = v;
      pix_color = c;
      pix_blank = b;
   endtask

   // One clock: model follows the edge, then all outputs are compared, then strobes drop.
   task automatic step();
      logic commit;
      @(posedge clk);
      commit = frame_start && (m_pend || pal_commit);
      if (commit) for (int i = 0; i < int'(D); i++) m_act[i] = m_sh[i];
      if (pal_we) m_sh[pal_addr] = pal_data;
      m_pend = commit ? 1'b0 : (m_pend || pal_commit);
      inflight.push_back({pix_valid, (pix_valid && !pix_blank) ? m_act[pix_color] : 24'h0});
      void'(inflight.pop_front());
      m_out = inflight[0];
      #1;
      check("out_valid", 32'(out_valid), 32'(m_out[24]));
      check("rgb", 32'({R, G, B}), 32'(m_out[23:0]));
      check("commit_pending", 32'(commit_pending), 32'(m_pend));
      @(negedge clk);
      frame_start = 1'b0;
      pal_we      = 1'b0;
      pal_commit  = 1'b0;
   endtask

   task automatic write(input logic [CB-1:0] a, input logic [23:0] d);
      pal_we = 1'b1;
      pal_addr = a;
      pal_data = d;
   endtask

   initial begin
      reset_n = 1'b0;
      pix(1'b0, '0, 1'b0);
      frame_start = 1'b0; pal_we = 1'b0; pal_commit = 1'b0;
      pal_addr = '0; pal_data = '0;
      model_reset();
      #1;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_rgb", 32'({R, G, B}), 32'd0);
      check("reset_pending", 32'(commit_pending), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Default palette lookups
      pix(1'b1, 3'd0, 1'b0); step();
      pix(1'b1, 3'd1, 1'b0); step();
      check("t1_c0", 32'({out_valid, R, G, B}), 32'h1112033);
      pix(1'b1, 3'd2, 1'b0); step();
      check("t1_c1", 32'({out_valid, R, G, B}), 32'h1fd610c);
      step();
      check("t1_c2", 32'({R, G, B}), 32'h0);

      // Shadow write without commit is invisible
      write(3'd2, 24'haabbcc); step();
      frame_start = 1'b1; step();
      step(); step();
      check("t2_nocommit", 32'({R, G, B}), 32'h0);

      // Commit then frame_start with colour-2 pixel in the same cycle
      pal_commit = 1'b1; step();
      check("t3_pending", 32'(commit_pending), 32'd1);
      pal_commit = 1'b1; step();
      check("t3_repeat", 32'(commit_pending), 32'd1);
      frame_start = 1'b1; step();
      check("t3_cleared", 32'(commit_pending), 32'd0);
      step();
      check("t3_newpal", 32'({R, G, B}), 32'haabbcc);

      // Write coincident with a same-cycle commit+frame_start
      pix(1'b1, 3'd3, 1'b0);
      write(3'd3, 24'h010203); pal_commit = 1'b1; frame_start = 1'b1; step();
      check("t4_nopend", 32'(commit_pending), 32'd0);
      step(); step();
      check("t4_oldval", 32'({R, G, B}), 32'h0);
      pal_commit = 1'b1; step();
      frame_start = 1'b1; step();
      step();
      check("t4_newval", 32'({R, G, B}), 32'h010203);

      // Blanking run then idle
      pix(1'b1, 3'd1, 1'b1);
      repeat (4) step();
      check("t5_blank", 32'({out_valid, R, G, B}), 32'h1000000);
      pix(1'b1, 3'd1, 1'b0); step(); step();
      check("t5_unblank", 32'({out_valid, R, G, B}), 32'h1fd610c);
      pix(1'b0, 3'd1, 1'b0); step(); step();
      check("t5_idle", 32'({out_valid, R, G, B}), 32'h0);

      // Reset with a pending commit and edits mid-stream
      write(3'd0, 24'h123456); pal_commit = 1'b1; pix(1'b1, 3'd3, 1'b0); step();
      step();
      #2 reset_n = 1'b0;
      #1;
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_rgb", 32'({R, G, B}), 32'd0);
      check("t6_pending", 32'(commit_pending), 32'd0);
      model_reset();
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      frame_start = 1'b1; pix(1'b1, 3'd0, 1'b0); step();
      pix(1'b1, 3'd3, 1'b0); step();
      check("t6_default0", 32'({R, G, B}), 32'h112033);
      step();
      check("t6_default3", 32'({R, G, B}), 32'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         pix(1'($urandom_range(0, 3) != 0), CB'($urandom), 1'($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 3) == 0) write(CB'($urandom), 24'($urandom));
         pal_commit  = ($urandom_range(0, 9) == 0);
         frame_start = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
